// File: rtl/rsa_host_ctrl.sv
// Host-side sequencer for the RSA exponentiation unit: holds operands, launches
// the unit through a one-cycle ARM gap, and reports done/error with a run-cycle timeout.
module rsa_host_ctrl #(
    parameter int TIMEOUT_CYC = 1023,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [7:0]       wdata,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             wr_err,
    output logic [7:0]       result,
    output logic [CNT_W-1:0] cycles,
    output logic             rsa_en,
    output logic [7:0]       rsa_P,
    output logic [7:0]       rsa_E,
    output logic [7:0]       rsa_M,
    output logic [7:0]       rsa_Const,
    input  logic             rsa_eoc,
    input  logic [7:0]       rsa_C
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ARM  = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] DONE = 3'd3;
    localparam logic [2:0] ERR  = 3'd4;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

    logic [2:0]       state;
    logic [7:0]       m_eff;
    logic [CNT_W-1:0] cnt_n;

    // A legal modulus is odd and at least 3.
    function automatic logic m_legal(input logic [7:0] m);
        return m[0] && (m >= 8'd3);
    endfunction

    // A write on the same cycle as start is seen by the modulus check.
    always_comb begin
        m_eff = rsa_M;
        if (wr_en && (addr == 2'd2))
            m_eff = wdata;
        cnt_n = cycles + CNT_W'(1);
    end

    // Outputs decode directly from the state register, so reset drops rsa_en at once.
    assign busy   = (state == ARM) || (state == RUN);
    assign rsa_en = (state == RUN);
    assign done   = (state == DONE);
    assign err    = (state == ERR);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            rsa_P     <= 8'h00;
            rsa_E     <= 8'h00;
            rsa_M     <= 8'h00;
            rsa_Const <= 8'h00;
            result    <= 8'h00;
            cycles    <= '0;
            wr_err    <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    if (wr_en)
                        wr_err <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    if (wr_en)
                        wr_err <= 1'b1;
                    cycles <= cnt_n;
                    if (rsa_eoc) begin
                        result <= rsa_C;
                        state  <= DONE;
                    end else if (cnt_n == TMO) begin
                        result <= 8'h00;
                        state  <= ERR;
                    end
                end
                default: begin
                    if (wr_en) begin
                        case (addr)
                            2'd0:    rsa_P     <= wdata;
                            2'd1:    rsa_E     <= wdata;
                            2'd2:    rsa_M     <= wdata;
                            default: rsa_Const <= wdata;
                        endcase
                    end
                    if (start) begin
                        wr_err <= 1'b0;
                        cycles <= '0;
                        if (m_legal(m_eff)) begin
                            state <= ARM;
                        end else begin
                            result <= 8'h00;
                            state  <= ERR;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Directed bench for rsa_host_ctrl: two instances (timeout 100 and 40) share the
// host write bus, each with its own start and a behavioural eoc model.
module tb_rsa_host_ctrl;

    logic        clk = 1'b0;
    logic        rstb;
    logic        wr_en;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic        start_a, start_b;

    logic        busy_a, done_a, err_a, wr_err_a, rsa_en_a, eoc_a;
    logic [7:0]  result_a, p_a, e_a, m_a, c_a, rsa_c_a;
    logic [15:0] cycles_a;

    logic        busy_b, done_b, err_b, wr_err_b, rsa_en_b, eoc_b;
    logic [7:0]  result_b, p_b, e_b, m_b, c_b, rsa_c_b;
    logic [15:0] cycles_b;

    int eoc_at_a = 0, eoc_at_b = 0;
    int run_a = 0, run_b = 0;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rsa_host_ctrl #(.TIMEOUT_CYC(100), .CNT_W(16)) dut_a (
        .clk(clk), .rstb(rstb), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .start(start_a), .busy(busy_a), .done(done_a), .err(err_a),
        .wr_err(wr_err_a), .result(result_a), .cycles(cycles_a),
        .rsa_en(rsa_en_a), .rsa_P(p_a), .rsa_E(e_a), .rsa_M(m_a),
        .rsa_Const(c_a), .rsa_eoc(eoc_a), .rsa_C(rsa_c_a)
    );

    rsa_host_ctrl #(.TIMEOUT_CYC(40), .CNT_W(16)) dut_b (
        .clk(clk), .rstb(rstb), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .start(start_b), .busy(busy_b), .done(done_b), .err(err_b),
        .wr_err(wr_err_b), .result(result_b), .cycles(cycles_b),
        .rsa_en(rsa_en_b), .rsa_P(p_b), .rsa_E(e_b), .rsa_M(m_b),
        .rsa_Const(c_b), .rsa_eoc(eoc_b), .rsa_C(rsa_c_b)
    );

    // RSA unit model: eoc is presented during the eoc_at-th enabled cycle.
    always @(negedge clk) begin
        run_a <= rsa_en_a ? run_a + 1 : 0;
        eoc_a <= (eoc_at_a != 0) && rsa_en_a && (run_a + 1 == eoc_at_a);
        run_b <= rsa_en_b ? run_b + 1 : 0;
        eoc_b <= (eoc_at_b != 0) && rsa_en_b && (run_b + 1 == eoc_at_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        step(1);
        wr_en = 1'b0;
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        step(1);
        start_a = 1'b0;
    endtask

    initial begin
        int n;
        rstb = 1'b0; wr_en = 1'b0; addr = 2'd0; wdata = 8'h00;
        start_a = 1'b0; start_b = 1'b0;
        eoc_a = 1'b0; eoc_b = 1'b0;
        rsa_c_a = 8'h1C; rsa_c_b = 8'h5A;
        step(2);
        rstb = 1'b1;
        step(1);

        chk("rst_busy",   busy_a,   0);
        chk("rst_done",   done_a,   0);
        chk("rst_err",    err_a,    0);
        chk("rst_wr_err", wr_err_a, 0);
        chk("rst_en",     rsa_en_a, 0);
        chk("rst_result", result_a, 0);
        chk("rst_cycles", cycles_a, 0);
        chk("rst_M",      m_a,      0);

        // Normal operation, eoc after 40 run cycles
        wr(2'd0, 8'h04); wr(2'd1, 8'h0D); wr(2'd2, 8'h21); wr(2'd3, 8'h0F);
        chk("op_P", p_a, 8'h04);
        chk("op_E", e_a, 8'h0D);
        chk("op_M", m_a, 8'h21);
        chk("op_C", c_a, 8'h0F);
        eoc_at_a = 40;
        pulse_a();
        chk("arm_busy", busy_a,   1);
        chk("arm_en",   rsa_en_a, 0);
        step(1);
        chk("run_en",   rsa_en_a, 1);
        n = 0;
        while (!done_a && !err_a && n < 200) begin step(1); n++; end
        chk("op_done",   done_a,   1);
        chk("op_result", result_a, 8'h1C);
        chk("op_cycles", cycles_a, 40);
        chk("op_busy",   busy_a,   0);
        chk("op_en_off", rsa_en_a, 0);

        // Illegal moduli
        wr(2'd2, 8'h20);
        pulse_a();
        chk("even_err",    err_a,    1);
        chk("even_en",     rsa_en_a, 0);
        chk("even_result", result_a, 8'h00);
        chk("even_cycles", cycles_a, 0);
        wr(2'd2, 8'h01);
        pulse_a();
        chk("one_err",  err_a,    1);
        step(1);
        chk("one_en",   rsa_en_a, 0);
        chk("one_busy", busy_a,   0);
        chk("one_res",  result_a, 8'h00);

        // Timeout; the M write lands on the start cycle and is used by the check
        eoc_at_a = 0;
        wr_en = 1'b1; addr = 2'd2; wdata = 8'h21; start_a = 1'b1;
        step(1);
        wr_en = 1'b0; start_a = 1'b0;
        chk("wrst_busy", busy_a, 1);
        n = 0;
        while (!err_a && n < 300) begin step(1); n++; end
        chk("tmo_edges",  n,        101);
        chk("tmo_err",    err_a,    1);
        chk("tmo_cycles", cycles_a, 100);
        chk("tmo_en",     rsa_en_a, 0);
        chk("tmo_result", result_a, 8'h00);

        // Write and start while running
        eoc_at_a = 40;
        pulse_a();
        step(5);
        wr_en = 1'b1; addr = 2'd0; wdata = 8'hFF; start_a = 1'b1;
        step(1);
        wr_en = 1'b0; start_a = 1'b0;
        chk("bw_P",      p_a,      8'h04);
        chk("bw_wr_err", wr_err_a, 1);
        chk("bw_busy",   busy_a,   1);
        n = 0;
        while (!done_a && !err_a && n < 200) begin step(1); n++; end
        chk("bw_done",   done_a,   1);
        chk("bw_cycles", cycles_a, 40);
        chk("bw_P2",     p_a,      8'h04);
        chk("bw_keep",   wr_err_a, 1);
        pulse_a();
        chk("bw_clear",  wr_err_a, 0);
        chk("bw_relnch", busy_a,   1);

        // Asynchronous reset mid-run
        step(5);
        chk("pre_rst_en", rsa_en_a, 1);
        #2 rstb = 1'b0;
        #1;
        chk("ar_en",     rsa_en_a, 0);
        chk("ar_busy",   busy_a,   0);
        chk("ar_P",      p_a,      0);
        chk("ar_E",      e_a,      0);
        chk("ar_M",      m_a,      0);
        chk("ar_Const",  c_a,      0);
        chk("ar_result", result_a, 0);
        step(1);
        rstb = 1'b1;
        step(1);
        chk("ar_idle", busy_a | done_a | err_a, 0);

        // eoc on the same edge as the timeout
        wr(2'd2, 8'h21);
        eoc_at_b = 40;
        start_b = 1'b1;
        step(1);
        start_b = 1'b0;
        chk("tie_busy", busy_b, 1);
        n = 0;
        while (!done_b && !err_b && n < 100) begin step(1); n++; end
        chk("tie_done",   done_b,   1);
        chk("tie_err",    err_b,    0);
        chk("tie_result", result_b, 8'h5A);
        chk("tie_cycles", cycles_b, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
